// File: rtl/wb_arbiter_rr_pkg.sv
// Shared definitions for the Wishbone interconnect blocks:
// arbiter state encodings and width helpers.
package wb_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((longint'(1) << i) < longint'(value)) r = i + 1;
    end
    return r;
  endfunction

  // An index bus is kept at least one bit wide so single-master builds still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping N-1 -> 0.
// Returns the winner both one-hot and as an index.
module rr_pick
  import wb_arbiter_rr_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    int  cand;
    logic found;
    gnt_o   = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    // Offset N checks 'last' itself, so a lone repeat requester still wins.
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_i) + k) % N;
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = IW'(cand);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone B3 arbiter: one shared slave, grant held for a whole cyc,
// per-grant watchdog that aborts hung accesses with err.
module wb_arbiter_rr
  import wb_arbiter_rr_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic                        wbs_we_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o,
  output logic                        timeout_o
);

  localparam int N   = NUM_MASTERS;
  localparam int SW  = DW / 8;
  localparam int IW  = idx_width(N);
  localparam int WDW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
  localparam bit WDOG_EN = (TIMEOUT > 0);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e     state_q;
  logic [N-1:0]   grant_q;
  logic [IW-1:0]  gidx_q;
  logic [IW-1:0]  last_q;
  logic [WDW-1:0] wdog_q;
  logic           abort_pulse_q;

  logic [N-1:0]   pick_gnt;
  logic [IW-1:0]  pick_idx;
  logic           pick_valid;

  logic g_cyc, g_stb, s_term, in_grant;

  rr_pick #(
    .N (N),
    .IW(IW)
  ) u_pick (
    .req_i  (wbm_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );

  assign g_cyc    = |(wbm_cyc_i & grant_q);
  assign g_stb    = |(wbm_stb_i & grant_q);
  assign s_term   = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign in_grant = (state_q == ARB_GRANT);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      gidx_q        <= '0;
      last_q        <= IW'(N - 1);
      wdog_q        <= '0;
      abort_pulse_q <= 1'b0;
    end else begin
      abort_pulse_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          wdog_q <= '0;
          if (pick_valid) begin
            grant_q <= pick_gnt;
            gidx_q  <= pick_idx;
            state_q <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (!g_cyc) begin
            last_q  <= gidx_q;
            grant_q <= '0;
            wdog_q  <= '0;
            state_q <= ARB_IDLE;
          end else if (g_stb && !s_term) begin
            // A termination in the final watchdog cycle takes the other branch, so it wins.
            if (WDOG_EN && wdog_q == WDOG_LAST) begin
              wdog_q        <= '0;
              abort_pulse_q <= 1'b1;
              state_q       <= ARB_ABORT;
            end else if (WDOG_EN && wdog_q != '1) begin
              wdog_q <= wdog_q + 1'b1;
            end
          end else begin
            wdog_q <= '0;
          end
        end
        ARB_ABORT: begin
          if (!g_cyc) begin
            last_q  <= gidx_q;
            grant_q <= '0;
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    for (int m = 0; m < N; m++) begin
      if (gidx_q == IW'(m)) begin
        wbs_adr_o = wbm_adr_i[m*AW +: AW];
        wbs_dat_o = wbm_dat_i[m*DW +: DW];
        wbs_sel_o = wbm_sel_i[m*SW +: SW];
        wbs_we_o  = wbm_we_i[m];
        wbs_cti_o = wbm_cti_i[m*3 +: 3];
        wbs_bte_o = wbm_bte_i[m*2 +: 2];
      end
    end
  end

  assign wbs_cyc_o = in_grant & g_cyc;
  assign wbs_stb_o = in_grant & g_stb;
  assign grant_o   = grant_q;
  assign timeout_o = abort_pulse_q;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_master
      assign wbm_dat_o[gi*DW +: DW] = wbs_dat_i;
      assign wbm_ack_o[gi] = grant_q[gi] & in_grant & wbs_ack_i;
      assign wbm_err_o[gi] = grant_q[gi] & ((in_grant & wbs_err_i) | abort_pulse_q);
      assign wbm_rty_o[gi] = grant_q[gi] & in_grant & wbs_rty_i;
    end
  endgenerate

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr: three masters, TIMEOUT=8, scoreboard of expected
// acknowledged beats and expected grant order.
module tb_wb_arbiter_rr;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct packed {
    logic [N-1:0]  who;
    logic [DW-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [N*AW-1:0]   adr;
  logic [N*DW-1:0]   dat;
  logic [N*SW-1:0]   sel;
  logic [N-1:0]      we, cyc, stb;
  logic [N*3-1:0]    cti;
  logic [N*2-1:0]    bte;
  logic [N*DW-1:0]   wbm_dat_o;
  logic [N-1:0]      wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;
  logic [SW-1:0]     wbs_sel_o;
  logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic [DW-1:0]     s_dat;
  logic              ack_drv, auto_ack, s_ack, s_err, s_rty;
  logic [N-1:0]      grant_o;
  logic              timeout_o;

  // A zero-wait slave in auto mode, otherwise acks are driven directly by the steps.
  assign s_ack = auto_ack ? wbs_stb_o : ack_drv;

  wb_arbiter_rr #(
    .NUM_MASTERS(N),
    .AW(AW),
    .DW(DW),
    .TIMEOUT(8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbm_adr_i(adr),
    .wbm_dat_i(dat),
    .wbm_sel_i(sel),
    .wbm_we_i (we),
    .wbm_cyc_i(cyc),
    .wbm_stb_i(stb),
    .wbm_cti_i(cti),
    .wbm_bte_i(bte),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_o(wbm_ack_o),
    .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o),
    .wbs_sel_o(wbs_sel_o),
    .wbs_we_o (wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o),
    .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o),
    .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(s_dat),
    .wbs_ack_i(s_ack),
    .wbs_err_i(s_err),
    .wbs_rty_i(s_rty),
    .grant_o  (grant_o),
    .timeout_o(timeout_o)
  );

  int checks   = 0;
  int failures = 0;
  beat_t        exp_q[$];
  logic [N-1:0] exp_g[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic c, input logic s, input logic [AW-1:0] a,
                       input logic [2:0] t);
    cyc[m] = c;
    stb[m] = s;
    adr[m*AW +: AW] = a;
    cti[m*3 +: 3] = t;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc = '0; stb = '0; we = '0; adr = '0; dat = '0; sel = '1; cti = '0; bte = '0;
    ack_drv = 1'b0; auto_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;
    step();
    step();
  endtask

  // Pops the next expected beat and compares the ack vector and the data seen by that master.
  task automatic expect_ack(input string tag);
    beat_t         e;
    logic [DW-1:0] seen;
    e    = exp_q.pop_front();
    seen = '0;
    for (int m = 0; m < N; m++) if (e.who[m]) seen = wbm_dat_o[m*DW +: DW];
    $display("txn %s: ack=%b data=%h", tag, wbm_ack_o, seen);
    chk(tag, {wbm_ack_o, seen}, {e.who, e.data});
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [N-1:0] acked, prev_g;
    int           idle_run;
    bit           first;

    // 1: reset state, then a single read by master 1
    do_reset();
    chk("rst_grant", grant_o, 0);
    chk("rst_slave", {wbs_cyc_o, wbs_stb_o, timeout_o}, 0);
    chk("rst_term", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 0);
    rst_n = 1'b1;
    drive(1, 1'b1, 1'b1, 32'h100, 3'b000);
    #1;
    chk("t1_lat0", wbs_cyc_o, 0);
    step();
    chk("t1_cyc", {wbs_cyc_o, wbs_stb_o}, 2'b11);
    chk("t1_grant", grant_o, 3'b010);
    chk("t1_adr", wbs_adr_o, 32'h100);
    s_dat = 32'hDEADBEEF;
    ack_drv = 1'b1;
    exp_q.push_back(beat_t'{who: 3'b010, data: 32'hDEADBEEF});
    #1;
    expect_ack("t1_ack");
    step();
    ack_drv = 1'b0;
    drive(1, 1'b0, 1'b0, '0, 3'b000);
    step();
    chk("t1_idle", grant_o, 0);

    // 2: all masters request continuously; grants must rotate 0,1,2,0
    do_reset();
    rst_n = 1'b1;
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    auto_ack = 1'b1;
    cyc = '1;
    stb = '1;
    prev_g = '0;
    idle_run = 0;
    first = 1'b1;
    for (int c = 0; c < 60 && exp_g.size() > 0; c++) begin
      @(negedge clk);
      acked = wbm_ack_o;
      if (grant_o != 0 && prev_g == 0) begin
        $display("txn t2: grant=%b idle_before=%0d", grant_o, idle_run);
        chk("t2_order", grant_o, exp_g.pop_front());
        if (!first) chk("t2_gap", idle_run, 1);
        first = 1'b0;
      end
      if (grant_o == 0) idle_run++;
      else idle_run = 0;
      prev_g = grant_o;
      @(posedge clk);
      #1;
      for (int m = 0; m < N; m++) begin
        if (acked[m]) begin
          cyc[m] = 1'b0;
          stb[m] = 1'b0;
        end else if (!cyc[m]) begin
          cyc[m] = 1'b1;
          stb[m] = 1'b1;
        end
      end
    end
    chk("t2_done", exp_g.size(), 0);

    // 3: master 0 four-beat burst while master 2 waits
    do_reset();
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b1, 32'h200, 3'b010);
    drive(2, 1'b1, 1'b1, 32'h300, 3'b000);
    step();
    chk("t3_grant0", grant_o, 3'b001);
    for (int b = 0; b < 4; b++) begin
      drive(0, 1'b1, 1'b1, 32'(32'h200 + b * 4), (b == 3) ? 3'b111 : 3'b010);
      s_dat = 32'(32'h1000 + b);
      ack_drv = 1'b1;
      exp_q.push_back(beat_t'{who: 3'b001, data: 32'(32'h1000 + b)});
      #1;
      chk("t3_cti", wbs_cti_o, (b == 3) ? 3'b111 : 3'b010);
      expect_ack("t3_beat");
      step();
    end
    ack_drv = 1'b0;
    drive(0, 1'b0, 1'b0, '0, 3'b000);
    step();
    chk("t3_gap", grant_o, 0);
    step();
    chk("t3_grant2", grant_o, 3'b100);
    chk("t3_adr2", wbs_adr_o, 32'h300);
    s_dat = 32'h2222;
    ack_drv = 1'b1;
    exp_q.push_back(beat_t'{who: 3'b100, data: 32'h2222});
    #1;
    expect_ack("t3_m2");
    step();
    ack_drv = 1'b0;
    drive(2, 1'b0, 1'b0, '0, 3'b000);
    step();

    // 4: slave never answers; watchdog aborts after 8 stalled cycles
    drive(1, 1'b1, 1'b1, 32'h400, 3'b000);
    step();
    chk("t4_grant", grant_o, 3'b010);
    for (int i = 0; i < 8; i++) begin
      chk("t4_wait", {wbs_cyc_o, timeout_o, wbm_err_o}, 5'b10000);
      step();
    end
    $display("txn t4: cyc=%b timeout=%b err=%b", wbs_cyc_o, timeout_o, wbm_err_o);
    chk("t4_abort", {wbs_cyc_o, wbs_stb_o, timeout_o, wbm_err_o}, 6'b001010);
    step();
    chk("t4_pulse_end", {wbs_cyc_o, timeout_o, wbm_err_o}, 0);
    chk("t4_hold", grant_o, 3'b010);
    drive(1, 1'b0, 1'b0, '0, 3'b000);
    step();
    chk("t4_idle", grant_o, 0);

    // 5: ack lands in the last watchdog cycle and must win
    drive(1, 1'b1, 1'b1, 32'h500, 3'b000);
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        s_dat = 32'h5555;
        ack_drv = 1'b1;
        exp_q.push_back(beat_t'{who: 3'b010, data: 32'h5555});
        #1;
        expect_ack("t5_ack");
      end
      chk("t5_no_err", {timeout_o, wbm_err_o}, 0);
      step();
    end
    ack_drv = 1'b0;
    #1;
    chk("t5_still", {wbs_cyc_o, timeout_o, wbm_err_o}, 5'b10000);
    drive(1, 1'b0, 1'b0, '0, 3'b000);
    step();

    // 6: reset mid-burst; master 0 regains first priority
    drive(1, 1'b1, 1'b1, 32'h600, 3'b010);
    step();
    chk("t6_grant", grant_o, 3'b010);
    s_dat = 32'h6000;
    ack_drv = 1'b1;
    exp_q.push_back(beat_t'{who: 3'b010, data: 32'h6000});
    #1;
    expect_ack("t6_beat");
    step();
    ack_drv = 1'b0;
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b1, 32'h700, 3'b000);
    drive(2, 1'b1, 1'b1, 32'h800, 3'b000);
    step();
    chk("t6_rst_cyc", {wbs_cyc_o, grant_o}, 0);
    chk("t6_rst_term", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 0);
    rst_n = 1'b1;
    drive(1, 1'b0, 1'b0, '0, 3'b000);
    step();
    $display("txn t6: grant after reset=%b", grant_o);
    chk("t6_winner", grant_o, 3'b001);

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
